// File: rtl/sr_tx_sequencer.sv
// Parallel-to-serial sequencer: a word is taken on valid/ready and shifted out MSB first, one bit per DIV clocks, then one done cycle.
// in_ready is high only in IDLE, so the producer is held off for the whole frame; SR_TX_PARITY_EN adds an even-parity bit period.
module sr_tx_sequencer #(
  parameter int N   = 8,
  parameter int DIV = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         sr_out,
  output logic         control,
  output logic         busy,
  output logic         done
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW = $clog2(N + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(N - 1);

`ifdef SR_TX_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_DONE   = 2'd2,
    ST_PARITY = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [N-1:0]  sr_q, sr_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic          bit_strobe;
`ifdef SR_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sr_q      <= '0;
      presc_q   <= '0;
      bit_cnt_q <= '0;
`ifdef SR_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      presc_q   <= presc_d;
      bit_cnt_q <= bit_cnt_d;
`ifdef SR_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    presc_d    = presc_q;
    bit_cnt_d  = bit_cnt_q;
`ifdef SR_TX_PARITY_EN
    par_d      = par_q;
`endif
    in_ready   = 1'b0;
    sr_out     = 1'b0;
    control    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    // With DIV=1 PRESC_MAX is 0, so every bit-period cycle is a strobe and presc stays 0.
    bit_strobe = (presc_q == PRESC_MAX);

    case (state_q)
      ST_IDLE: begin
        in_ready = ~reset;
        if (in_valid && in_ready) begin
          sr_d      = in_data;
          presc_d   = '0;
          bit_cnt_d = '0;
`ifdef SR_TX_PARITY_EN
          par_d     = ^in_data;
`endif
          state_d   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        busy    = 1'b1;
        sr_out  = sr_q[N-1];
        control = bit_strobe;
        presc_d = bit_strobe ? '0 : presc_q + 1'b1;
        if (bit_strobe) begin
          sr_d      = {sr_q[N-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
`ifdef SR_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_DONE;
`endif
          end
        end
      end

`ifdef SR_TX_PARITY_EN
      ST_PARITY: begin
        busy    = 1'b1;
        sr_out  = par_q;
        control = bit_strobe;
        presc_d = bit_strobe ? '0 : presc_q + 1'b1;
        if (bit_strobe) begin
          state_d = ST_DONE;
        end
      end
`endif

      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  a_ctrl_in_frame: assert property (@(posedge clk) disable iff (reset) control |-> busy);
  a_done_single:   assert property (@(posedge clk) disable iff (reset) done |=> !done);
  a_idle_quiet:    assert property (@(posedge clk) disable iff (reset)
                                    !busy |-> (!sr_out && !control && !done));

endmodule

// File: tb/tb_sr_tx_sequencer.sv
// Bench for sr_tx_sequencer: DIV=4 and DIV=1 instances, directed frame table, async-reset corner and a
// randomized run, all compared against a frame-timeline reference model.
`timescale 1ns/1ps
module tb_sr_tx_sequencer;

  localparam int N = 8;
`ifdef SR_TX_PARITY_EN
  localparam int NB = N + 1;
`else
  localparam int NB = N;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] in_data0 = '0;
  logic [N-1:0] in_data1 = '0;
  logic         in_valid0 = 1'b0;
  logic         in_valid1 = 1'b0;
  logic         in_ready0, sr_out0, control0, busy0, done0;
  logic         in_ready1, sr_out1, control1, busy1, done1;
  int           n_checks = 0;
  int           n_pass = 0;

  always #5 clk = ~clk;

  sr_tx_sequencer #(.N(N), .DIV(4)) u_dut0 (
    .clk(clk), .reset(reset), .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
    .sr_out(sr_out0), .control(control0), .busy(busy0), .done(done0)
  );

  sr_tx_sequencer #(.N(N), .DIV(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .sr_out(sr_out1), .control(control1), .busy(busy1), .done(done1)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: t counts cycles since the accept edge (0 = idle); a frame is NB bit periods then one done cycle.
  int           t0 = 0, t1 = 0;
  logic [N-1:0] w0 = '0, w1 = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) t0 <= 0;
    else if (t0 == 0) begin
      if (in_valid0) begin t0 <= 1; w0 <= in_data0; end
    end else t0 <= (t0 == NB * 4 + 1) ? 0 : t0 + 1;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) t1 <= 0;
    else if (t1 == 0) begin
      if (in_valid1) begin t1 <= 1; w1 <= in_data1; end
    end else t1 <= (t1 == NB + 1) ? 0 : t1 + 1;
  end

  // Returns {in_ready, sr_out, control, busy, done}.
  function automatic logic [4:0] model_out(input int t, input logic [N-1:0] w, input int div, input logic rst);
    int   idx;
    logic b;
    if (t == 0) return {~rst, 4'b0000};
    if (t <= NB * div) begin
      idx = (t - 1) / div;
      b   = (idx < N) ? w[N-1-idx] : ^w;
      return {1'b0, b, ((t % div) == 0), 1'b1, 1'b0};
    end
    return 5'b00011;
  endfunction

  always @(negedge clk) begin
    check("model_div4", {in_ready0, sr_out0, control0, busy0, done0}, model_out(t0, w0, 4, reset));
    check("model_div1", {in_ready1, sr_out1, control1, busy1, done1}, model_out(t1, w1, 1, reset));
  end

  typedef struct {
    bit           dut;
    logic [N-1:0] word;
    bit           hold;
    logic [N-1:0] exp_ser;
    logic         exp_par;
    int           exp_done;
  } vec_t;

  vec_t tbl[6];

  task automatic wait_ready(input bit which);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((which ? in_ready1 : in_ready0) === 1'b1) begin ok = 1; break; end
    end
    if (!ok) check("ready_timeout", 0, 1);
  endtask

  task automatic run_frame(input vec_t v);
    int           div = v.dut ? 1 : 4;
    int           k;
    int           ctrl_cnt = 0;
    int           done_cyc = 0;
    logic [N-1:0] got = '0;
    logic         par = 1'b0;
    bit           held_ok = 1, pos_ok = 1, rdy_after = 0, second = 0;
    logic         s, ctl, dn, rdy, bsy;
    wait_ready(v.dut);
    if (v.dut) begin in_valid1 = 1'b1; in_data1 = v.word; end
    else       begin in_valid0 = 1'b1; in_data0 = v.word; end
    @(posedge clk);
    #1;
    if (v.dut) begin in_valid1 = v.hold; in_data1 = v.hold ? 8'hFF : ~v.word; end
    else       begin in_valid0 = v.hold; in_data0 = v.hold ? 8'hFF : ~v.word; end
    for (int c = 1; c <= NB * div + 3; c++) begin
      @(negedge clk);
      s   = v.dut ? sr_out1   : sr_out0;
      ctl = v.dut ? control1  : control0;
      dn  = v.dut ? done1     : done0;
      rdy = v.dut ? in_ready1 : in_ready0;
      bsy = v.dut ? busy1     : busy0;
      if (c <= NB * div) begin
        k = (c - 1) / div;
        if (((c - 1) % div) == 0) begin
          if (k < N) got[N-1-k] = s; else par = s;
        end else if (s !== ((k < N) ? got[N-1-k] : par)) held_ok = 0;
      end
      if (c <= NB * div + 2) begin
        if (ctl === 1'b1) begin
          ctrl_cnt++;
          if ((c % div) != 0 || c > NB * div) pos_ok = 0;
        end
        if (dn === 1'b1) done_cyc = (done_cyc == 0) ? c : -1;
      end
      if (c == NB * div + 2) rdy_after = (rdy === 1'b1);
      if (c == NB * div + 3) second = (bsy === 1'b1) && (s === 1'b1);
    end
    if (v.dut) in_valid1 = 1'b0; else in_valid0 = 1'b0;
    check("serial_word", got, v.exp_ser);
    check("bit_held", held_ok, 1);
    check("ctrl_count", ctrl_cnt, NB);
    check("ctrl_position", pos_ok, 1);
    check("done_cycle", done_cyc, v.exp_done);
    check("ready_after_done", rdy_after, 1);
    check("next_accept", second, v.hold);
`ifdef SR_TX_PARITY_EN
    check("parity_bit", par, v.exp_par);
`endif
  endtask

  initial begin
    tbl[0] = '{1'b0, 8'hA5, 1'b0, 8'hA5, 1'b0, NB * 4 + 1};
    tbl[1] = '{1'b0, 8'hA5, 1'b1, 8'hA5, 1'b0, NB * 4 + 1};
    tbl[2] = '{1'b0, 8'h07, 1'b0, 8'h07, 1'b1, NB * 4 + 1};
    tbl[3] = '{1'b1, 8'h81, 1'b0, 8'h81, 1'b0, NB + 1};
    tbl[4] = '{1'b1, 8'h07, 1'b0, 8'h07, 1'b1, NB + 1};
    tbl[5] = '{1'b0, 8'hC3, 1'b0, 8'hC3, 1'b0, NB * 4 + 1};

    // Reset held with in_valid high: nothing may be accepted until reset is low at an edge.
    in_valid0 = 1'b1;
    in_data0  = 8'hA5;
    #1 reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_outs", {in_ready0, sr_out0, control0, busy0, done0}, 5'b00000);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    #1 check("rel_ready", {in_ready0, busy0}, 2'b10);
    @(posedge clk);
    #1 check("first_accept", busy0, 1'b1);
    in_valid0 = 1'b0;

    for (int i = 0; i < 5; i++) run_frame(tbl[i]);

    // Async reset in the strobe cycle of bit 3 of 8'h3C.
    wait_ready(1'b0);
    in_valid0 = 1'b1;
    in_data0  = 8'h3C;
    @(posedge clk);
    #1;
    in_valid0 = 1'b0;
    in_data0  = 8'h00;
    repeat (15) @(posedge clk);
    #2;
    check("pre_reset", {sr_out0, control0, busy0}, 3'b111);
    reset = 1'b1;
    #1 check("async_reset", {in_ready0, sr_out0, control0, busy0, done0}, 5'b00000);
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    run_frame(tbl[5]);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_valid0 = ($urandom_range(0, 3) == 0);
      in_data0  = N'($urandom);
      in_valid1 = ($urandom_range(0, 2) == 0);
      in_data1  = N'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
      end
    end
    @(negedge clk);
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    repeat (60) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sr_tx_sequencer.md
Name: sr_tx_sequencer

Overview:
- Controller that sequences a parameterised parallel-to-serial shift register.
- Accepts an N-bit word over a valid/ready handshake, then shifts it out MSB first, one bit every DIV clocks.
- Drives a one-cycle shift strobe (control), busy and done status.
- Sits between a parallel producer and a serial sink or line driver in the serial-link datapath.

Parameters:
- N, 8, word width in bits; N >= 2.
- DIV, 4, clock cycles per serial bit; DIV >= 1.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  N  parallel word to transmit.
- in_valid  input  1  producer offers in_data.
- in_ready  output  1  sequencer can accept a word.
- sr_out  output  1  serial bit, MSB first.
- control  output  1  shift strobe; high for the last cycle of each bit period.
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse at the end of a frame.

Behaviour:
- Reset: asynchronous, takes effect immediately, including mid-frame.
  - State -> IDLE; shift reg, prescaler and bit counter -> 0.
  - sr_out=0, control=0, busy=0, done=0.
  - in_ready=0 while reset is high.
- Internal state: state (IDLE, SHIFT, DONE, plus PARITY with the option); sr[N-1:0]; presc (0..DIV-1); bit_cnt of width clog2(N+1).
- IDLE:
  - in_ready = 1 (and reset low); busy=0; sr_out=0.
  - in_valid & in_ready at a posedge (edge E0): sr <= in_data, presc <= 0, bit_cnt <= 0, state <= SHIFT.
- SHIFT:
  - busy=1, in_ready=0.
  - sr_out = sr[N-1] (combinational from registers).
  - presc increments each cycle and wraps at DIV-1.
  - control = (presc == DIV-1), combinational.
  - On a control edge: sr shifts left with zero fill and bit_cnt increments.
  - Control edge with bit_cnt == N-1: state <= DONE (or PARITY with the option).
- Timing, relative to E0:
  - Bit k (MSB = k0) is on sr_out in cycles k*DIV+1 .. (k+1)*DIV.
  - control is high in cycles DIV, 2*DIV, ..., N*DIV.
- DONE:
  - Lasts exactly one cycle: done=1, busy=1, in_ready=0, sr_out=0.
  - Then state -> IDLE.
  - Earliest next accept is the cycle after DONE; minimum frame period N*DIV+2 cycles.
- in_valid is ignored outside IDLE; in_data is sampled only at the accept edge, so later changes have no effect.
- DIV=1: presc is constant 0; control is high on every SHIFT cycle.
- control, sr_out and done are never high in IDLE.
- No X propagation from in_data except into sr.

Optional Feature:
- Macro: SR_TX_PARITY_EN.
- Defined:
  - After the last data strobe, state <= PARITY for DIV cycles.
  - sr_out = even-parity bit (XOR of the captured word, latched at accept).
  - control pulses on the last PARITY cycle, then DONE.
  - Frame = (N+1)*DIV shift cycles; done lands in cycle (N+1)*DIV+1.
- Undefined: PARITY state and parity register are absent; SHIFT goes directly to DONE.

Test Plan:
1. Assert reset for 3 cycles with in_valid=1 -> sr_out/control/busy/done=0, in_ready=0; after release in_ready=1 and no accept occurs until in_valid is sampled with reset low.
2. N=8, DIV=4, send 8'hA5 -> sr_out=1,0,1,0,0,1,0,1, each bit held 4 cycles (cycles 1-32); control high in cycles 4,8,...,32; done=1 only in cycle 33; in_ready=1 in cycle 34.
3. Hold in_valid=1 with in_data changing to 8'hFF during the 8'hA5 frame -> serial output is still 8'hA5; 8'hFF is accepted at the first IDLE edge after done, and its first bit appears exactly N*DIV+2 cycles after the first accept.
4. Assert reset asynchronously mid-cycle during bit 3 of 8'h3C -> sr_out, busy and control drop at once without waiting for clk; after release, a new 8'hC3 frame transmits correctly from the MSB.
5. DIV=1 instance, send 8'h81 -> sr_out=1,0,0,0,0,0,0,1 on consecutive cycles 1-8; control high in all 8 cycles; done in cycle 9.
6. With SR_TX_PARITY_EN, DIV=4, send 8'hA5 then 8'h07 -> ninth bit 0 for 8'hA5 and 1 for 8'h07, each held 4 cycles; 9 control pulses; done in cycle 37.
